// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: latches one branch, evaluates it for one cycle,
// optionally issues a one-cycle redirect, and trains a 16-entry 2-bit BHT.
module branch_resolve_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1Data,
    input  logic [31:0] i_rs2Data,
    input  logic        i_predTaken,
    input  logic        i_kill,
    input  logic [31:0] i_fetchPc,
    output logic        o_predTaken,
    output logic        o_valid,
    output logic        o_taken,
    output logic [31:0] o_target,
    output logic        o_mispredict,
    output logic        o_illegal,
    output logic        o_flush,
    output logic [31:0] o_redirectPc
);

    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic [2:0]  r_funct3;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic        r_pred;
    logic [1:0]  r_bht [16];

    logic [32:0] w_sdiff;
    logic [32:0] w_udiff;
    logic        w_cond;
    logic        w_legal;
    logic        w_taken;
    logic        w_mispredict;
    logic        w_eval;
    logic        w_redir;
    logic [31:0] w_target;
    logic [31:0] w_fallthru;
    logic [3:0]  w_idx;

    // The sign/zero-extended 33-bit difference gives the less-than result without overflow cases.
    assign w_sdiff    = {r_rs1[31], r_rs1} - {r_rs2[31], r_rs2};
    assign w_udiff    = {1'b0, r_rs1} - {1'b0, r_rs2};
    assign w_target   = r_pc + r_imm;
    assign w_fallthru = r_pc + 32'd4;
    assign w_idx      = r_pc[5:2];

    always_comb begin
        w_cond  = 1'b0;
        w_legal = 1'b1;
        case (r_funct3)
            3'b000:  w_cond = (r_rs1 == r_rs2);
            3'b001:  w_cond = (r_rs1 != r_rs2);
            3'b100:  w_cond = w_sdiff[32];
            3'b101:  w_cond = ~w_sdiff[32];
            3'b110:  w_cond = w_udiff[32];
            3'b111:  w_cond = ~w_udiff[32];
            default: w_legal = 1'b0;
        endcase
    end

    assign w_taken      = w_legal & w_cond;
    assign w_mispredict = w_legal & (w_taken ^ r_pred);
    assign w_eval       = (r_state == EVAL) & ~i_kill;
    assign w_redir      = (r_state == REDIRECT) & ~i_kill;

    assign o_ready      = (r_state == IDLE) & ~i_kill & ~i_reset;
    assign o_valid      = w_eval;
    assign o_taken      = w_eval & w_taken;
    assign o_mispredict = w_eval & w_mispredict;
    assign o_illegal    = w_eval & ~w_legal;
    assign o_target     = w_eval ? w_target : 32'd0;
    assign o_flush      = w_redir;
    assign o_redirectPc = w_redir ? (w_taken ? w_target : w_fallthru) : 32'd0;
    assign o_predTaken  = r_bht[i_fetchPc[5:2]][1];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_pc     <= 32'd0;
            r_imm    <= 32'd0;
            r_funct3 <= 3'd0;
            r_rs1    <= 32'd0;
            r_rs2    <= 32'd0;
            r_pred   <= 1'b0;
            for (int i = 0; i < 16; i++) r_bht[i] <= 2'b01;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid && !i_kill) begin
                        r_pc     <= i_pc;
                        r_imm    <= i_imm;
                        r_funct3 <= i_funct3;
                        r_rs1    <= i_rs1Data;
                        r_rs2    <= i_rs2Data;
                        r_pred   <= i_predTaken;
                        r_state  <= EVAL;
                    end
                end
                EVAL: begin
                    if (i_kill) begin
                        r_state <= IDLE;
                    end else begin
                        if (w_legal) begin
                            if (w_taken && r_bht[w_idx] != 2'b11)
                                r_bht[w_idx] <= r_bht[w_idx] + 2'd1;
                            else if (!w_taken && r_bht[w_idx] != 2'b00)
                                r_bht[w_idx] <= r_bht[w_idx] - 2'd1;
                        end
                        r_state <= w_mispredict ? REDIRECT : IDLE;
                    end
                end
                REDIRECT: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl with hand-computed expectations.
module tb_branch_resolve_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_pc = '0;
    logic [31:0] i_imm = '0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_rs1Data = '0;
    logic [31:0] i_rs2Data = '0;
    logic        i_predTaken = 1'b0;
    logic        i_kill = 1'b0;
    logic [31:0] i_fetchPc = '0;
    logic        o_predTaken;
    logic        o_valid;
    logic        o_taken;
    logic [31:0] o_target;
    logic        o_mispredict;
    logic        o_illegal;
    logic        o_flush;
    logic [31:0] o_redirectPc;

    int n_chk  = 0;
    int n_pass = 0;

    branch_resolve_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_imm(i_imm), .i_funct3(i_funct3),
        .i_rs1Data(i_rs1Data), .i_rs2Data(i_rs2Data), .i_predTaken(i_predTaken),
        .i_kill(i_kill), .i_fetchPc(i_fetchPc), .o_predTaken(o_predTaken),
        .o_valid(o_valid), .o_taken(o_taken), .o_target(o_target),
        .o_mispredict(o_mispredict), .o_illegal(o_illegal), .o_flush(o_flush),
        .o_redirectPc(o_redirectPc)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic next_cycle();
        @(negedge i_clk);
        #1;
    endtask

    // Presents one request in IDLE, then returns settled inside the EVAL cycle.
    task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
        @(negedge i_clk);
        i_pc = pc; i_imm = imm; i_funct3 = f3;
        i_rs1Data = rs1; i_rs2Data = rs2; i_predTaken = pred; i_valid = 1'b1;
        #1;
        chk("issue_ready", o_ready, 1);
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        i_fetchPc = pc;
        #1;
        chk(tag, o_predTaken, exp);
    endtask

    initial begin
        // Reset state
        i_fetchPc = 32'h40;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_flush", o_flush, 0);
        chk("rst_target", o_target, 0);
        chk("rst_redir", o_redirectPc, 0);
        chk("rst_pred40", o_predTaken, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        chk("rel_ready", o_ready, 1);
        chk("rel_taken", o_taken, 0);

        // BEQ taken, predicted not-taken: mispredict then redirect
        issue(32'h100, 32'h20, 3'b000, 32'h1234, 32'h1234, 1'b0);
        chk("beq_valid", o_valid, 1);
        chk("beq_taken", o_taken, 1);
        chk("beq_target", o_target, 32'h120);
        chk("beq_misp", o_mispredict, 1);
        chk("beq_ready_eval", o_ready, 0);
        pred_at("beq_pre_update", 32'h100, 0);
        next_cycle();
        chk("beq_flush", o_flush, 1);
        chk("beq_redir", o_redirectPc, 32'h120);
        chk("beq_valid_redir", o_valid, 0);
        pred_at("beq_bht0", 32'h100, 1);
        next_cycle();
        chk("beq_flush_done", o_flush, 0);
        chk("beq_ready_back", o_ready, 1);

        // Signed vs unsigned less-than on the same operands
        issue(32'h204, 32'h40, 3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1);
        chk("blt_taken", o_taken, 1);
        chk("blt_misp", o_mispredict, 0);
        chk("blt_target", o_target, 32'h244);
        next_cycle();
        chk("blt_noflush", o_flush, 0);
        chk("blt_ready", o_ready, 1);
        issue(32'h204, 32'h40, 3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("bltu_taken", o_taken, 0);
        chk("bltu_misp", o_mispredict, 0);
        next_cycle();
        chk("bltu_noflush", o_flush, 0);

        // Saturation at 2'b11, then two decrements show 11 -> 10 -> 01
        for (int k = 0; k < 3; k++) begin
            issue(32'h10, 32'h8, 3'b000, 32'h5, 32'h5, 1'b1);
            chk("sat_taken", o_taken, 1);
            next_cycle();
            pred_at("sat_pred", 32'h10, 1);
        end
        issue(32'h10, 32'h8, 3'b001, 32'h5, 32'h5, 1'b0);
        chk("bne_taken", o_taken, 0);
        next_cycle();
        pred_at("dec1_pred", 32'h10, 1);
        issue(32'h10, 32'h8, 3'b001, 32'h5, 32'h5, 1'b0);
        next_cycle();
        pred_at("dec2_pred", 32'h10, 0);

        // BGE not taken at the top of the address space: both sums wrap
        issue(32'hFFFF_FFFC, 32'h8, 3'b101, 32'h8000_0000, 32'h0, 1'b1);
        chk("bge_taken", o_taken, 0);
        chk("bge_misp", o_mispredict, 1);
        chk("bge_target", o_target, 32'h4);
        next_cycle();
        chk("bge_flush", o_flush, 1);
        chk("bge_redir", o_redirectPc, 32'h0);
        next_cycle();
        pred_at("bge_bht15", 32'hFFFF_FFFC, 0);

        // Illegal funct3: no taken, no mispredict, no flush, BHT entry 0 untouched (still 10)
        issue(32'h300, 32'h10, 3'b010, 32'h7, 32'h7, 1'b0);
        chk("ill_valid", o_valid, 1);
        chk("ill_illegal", o_illegal, 1);
        chk("ill_taken", o_taken, 0);
        chk("ill_misp", o_mispredict, 0);
        next_cycle();
        chk("ill_noflush", o_flush, 0);
        chk("ill_ready", o_ready, 1);
        chk("ill_illegal_off", o_illegal, 0);
        pred_at("ill_bht0", 32'h300, 1);

        // Kill during EVAL of a mispredicted branch
        issue(32'h108, 32'h10, 3'b000, 32'h9, 32'h9, 1'b0);
        i_kill = 1'b1;
        #1;
        chk("kill_valid", o_valid, 0);
        chk("kill_misp", o_mispredict, 0);
        chk("kill_flush", o_flush, 0);
        @(negedge i_clk);
        i_kill = 1'b0;
        #1;
        chk("kill_ready", o_ready, 1);
        chk("kill_flush_next", o_flush, 0);
        pred_at("kill_no_update", 32'h108, 0);

        // Kill during REDIRECT suppresses the flush
        issue(32'h10C, 32'h10, 3'b000, 32'h3, 32'h3, 1'b0);
        next_cycle();
        i_kill = 1'b1;
        #1;
        chk("kill_redir_flush", o_flush, 0);
        chk("kill_redir_pc", o_redirectPc, 0);
        @(negedge i_clk);
        i_kill = 1'b0;
        #1;
        chk("kill_redir_ready", o_ready, 1);

        // Kill in IDLE blocks acceptance
        @(negedge i_clk);
        i_valid = 1'b1; i_kill = 1'b1; i_funct3 = 3'b000;
        #1;
        chk("idle_kill_ready", o_ready, 0);
        @(negedge i_clk);
        i_valid = 1'b0; i_kill = 1'b0;
        #1;
        chk("idle_kill_noeval", o_valid, 0);
        chk("idle_kill_ready2", o_ready, 1);

        // Reset in the middle of EVAL abandons the branch and clears the BHT
        issue(32'h114, 32'h10, 3'b000, 32'h1, 32'h1, 1'b0);
        i_reset = 1'b1;
        #1;
        chk("rstmid_valid", o_valid, 0);
        chk("rstmid_ready", o_ready, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        chk("rstmid_ready_rel", o_ready, 1);
        chk("rstmid_noflush", o_flush, 0);
        pred_at("rstmid_bht0", 32'h100, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
